// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a sync_fifo and its user.
// master: drives write/read requests and write data (the FIFO user).
// slave : the FIFO; drives read data, valid strobe, status flags and fill level.
interface sync_fifo_if #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned ADDR_LEN = 8
);
    logic                wincr_i;
    logic [DATA_LEN-1:0] wdata_i;
    logic                rincr_i;
    logic [DATA_LEN-1:0] rdata_o;
    logic                rvalid_o;
    logic                wfull_o;
    logic                rempty_o;
    logic                walmost_full_o;
    logic                ralmost_empty_o;
    logic [ADDR_LEN:0]   count_o;
    logic                overflow_o;
    logic                underflow_o;

    modport master (
        output wincr_i, wdata_i, rincr_i,
        input  rdata_o, rvalid_o, wfull_o, rempty_o, walmost_full_o,
               ralmost_empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  wincr_i, wdata_i, rincr_i,
        output rdata_o, rvalid_o, wfull_o, rempty_o, walmost_full_o,
               ralmost_empty_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary pointers, almost-full/almost-empty thresholds,
// fill level, sticky overflow/underflow flags and optional first-word-fall-through.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - sync_fifo_if.slave: wincr_i/wdata_i/rincr_i in; rdata_o, rvalid_o,
//          wfull_o, rempty_o, walmost_full_o, ralmost_empty_o, count_o,
//          overflow_o, underflow_o out
module sync_fifo #(
    parameter int unsigned DATA_LEN  = 32,
    parameter int unsigned ADDR_LEN  = 8,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AFULL_TH  = (1 << ADDR_LEN) - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input logic       clk,
    input logic       rst,
    sync_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_LEN;
    localparam int unsigned PTR_W = ADDR_LEN + 1;

    logic [DATA_LEN-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [PTR_W-1:0] count;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;

    // Status decoded only from registered pointers; modulo subtraction handles wrap.
    assign count  = wptr_q - rptr_q;
    assign full   = (count == PTR_W'(DEPTH));
    assign empty  = (count == PTR_W'(0));
    assign wr_acc = bus.wincr_i && !full;
    assign rd_acc = bus.rincr_i && !empty;

    // Next-state for pointers and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (bus.wincr_i && full) begin
            overflow_d = 1'b1;
        end
        if (bus.rincr_i && empty) begin
            underflow_d = 1'b1;
        end
    end

    // State registers; reset dominates any same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wptr_q[ADDR_LEN-1:0]] <= bus.wdata_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; rincr_i pops it.
            assign bus.rdata_o  = mem_q[rptr_q[ADDR_LEN-1:0]];
            assign bus.rvalid_o = !empty;
        end else begin : g_reg_read
            logic [DATA_LEN-1:0] rdata_q, rdata_d;
            logic                rvalid_q, rvalid_d;

            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = 1'b0;
                if (rd_acc) begin
                    rdata_d  = mem_q[rptr_q[ADDR_LEN-1:0]];
                    rvalid_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign bus.rdata_o  = rdata_q;
            assign bus.rvalid_o = rvalid_q;
        end
    endgenerate

    assign bus.count_o         = count;
    assign bus.wfull_o         = full;
    assign bus.rempty_o        = empty;
    assign bus.walmost_full_o  = (count >= PTR_W'(AFULL_TH));
    assign bus.ralmost_empty_o = (count <= PTR_W'(AEMPTY_TH));
    assign bus.overflow_o      = overflow_q;
    assign bus.underflow_o     = underflow_q;
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the same-clock successor to the team's dual-clock FIFO, for buffering inside one clock domain without pointer synchronisers. Adds configurable almost-full/almost-empty thresholds, a fill-level output, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. Storage is an internal register array. Pointers are plain binary, since both sides share `clk`.

## Interface
- `DATA_LEN`, default 32: word width in bits.
- `ADDR_LEN`, default 8: address width.
  - Depth `DEPTH = 2**ADDR_LEN`.
  - Legal range 1..12.
- `FWFT`, default 0: read mode.
  - 0 = registered read with `rvalid_o` strobe.
  - 1 = head word presented on `rdata_o` while non-empty.
- `AFULL_TH`, default `DEPTH-2`: almost-full threshold, legal 1..`DEPTH`.
- `AEMPTY_TH`, default 2: almost-empty threshold, legal 0..`DEPTH-1`.

Ports (direction, width, meaning):
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `wincr_i`, in, 1: write request.
- `wdata_i`, in, `DATA_LEN`: write data.
- `rincr_i`, in, 1: read (pop) request.
- `rdata_o`, out, `DATA_LEN`: read data.
- `rvalid_o`, out, 1: `rdata_o` updated this cycle (FWFT=0); equals `!rempty_o` (FWFT=1).
- `wfull_o`, out, 1: FIFO holds `DEPTH` words.
- `rempty_o`, out, 1: FIFO holds 0 words.
- `walmost_full_o`, out, 1: fill level >= `AFULL_TH`.
- `ralmost_empty_o`, out, 1: fill level <= `AEMPTY_TH`.
- `count_o`, out, `ADDR_LEN+1`: current fill level, 0..`DEPTH`.
- `overflow_o`, out, 1: sticky; a write was attempted while full.
- `underflow_o`, out, 1: sticky; a read was attempted while empty.

## Operation
- State:
  - `wptr` and `rptr`, each `ADDR_LEN+1` bits, binary.
  - Memory index is the pointer's low `ADDR_LEN` bits.
  - The MSB distinguishes full from empty on wrap.
- Derived values, all decoded from registered pointers only (no combinational path from `wincr_i`/`rincr_i`):
  - `count_o = wptr - rptr`, modulo 2^(`ADDR_LEN+1`).
  - `wfull_o = (count_o == DEPTH)`.
  - `rempty_o = (count_o == 0)`.
  - Almost flags are compared against `count_o`.
- Write accepted when `wincr_i && !wfull_o`: `mem[wptr[ADDR_LEN-1:0]] <= wdata_i`, `wptr` increments.
- Read accepted when `rincr_i && !rempty_o`: `rptr` increments.
- Simultaneous accepted read and write: both happen; `count_o` is unchanged.
  - When full, the write is rejected and the read is accepted (full is registered).
  - When empty, the read is rejected and the write is accepted. No same-cycle bypass.
- Rejected requests:
  - No pointer change and no memory write.
  - A rejected write sets `overflow_o`; a rejected read sets `underflow_o`.
  - Both flags hold until `rst`.
- FWFT=0 read path:
  - On an accepted read, `rdata_o <= mem[rptr]` and `rvalid_o` pulses 1 for one cycle.
  - Otherwise `rdata_o` holds its value and `rvalid_o` is 0.
- FWFT=1 read path:
  - `rdata_o = mem[rptr[ADDR_LEN-1:0]]`, combinational array read.
  - `rincr_i` acknowledges (pops) the displayed word.
  - `rdata_o` is don't-care while `rempty_o` is 1.
- Wrap-around: pointers roll over from 2^(`ADDR_LEN+1`)-1 to 0; the modulo subtraction keeps `count_o` correct across the wrap.
- Reset (`rst` = 1 at a clock edge) dominates any same-cycle request. Reset values:
  - `wptr` = `rptr` = 0, `count_o` = 0.
  - `rempty_o` = 1, `wfull_o` = 0.
  - `ralmost_empty_o` = 1, `walmost_full_o` = 0.
  - `rdata_o` = 0, `rvalid_o` = 0.
  - `overflow_o` = `underflow_o` = 0.
  - Memory contents are not reset. Reset mid-stream discards all stored words.

## Timing
- Write-to-status latency: flags and `count_o` reflect an accepted write on the cycle after the write edge.
- Write-to-read latency (FWFT=1): a word written into an empty FIFO on edge N appears on `rdata_o` with `rempty_o` = 0 after edge N.
- Write-to-read latency (FWFT=0): a read request can be accepted in cycle N+1; data and `rvalid_o` appear after edge N+1.
- Throughput: sustained 1 write and 1 read per cycle.
- Status-flag timing: all status flags are registered-derived, with no combinational path from request inputs to any output. In FWFT mode, `rdata_o` depends only on `rptr` and memory.

## Test plan
All scenarios use `DATA_LEN`=8, `ADDR_LEN`=2 (`DEPTH`=4), `AFULL_TH`=3, `AEMPTY_TH`=1.
1. Reset and basic order, FWFT=0.
   - After `rst`: `rempty_o`=1, `count_o`=0, `ralmost_empty_o`=1.
   - Write 0xA1, 0xA2, 0xA3, then read 3 times.
   - `rdata_o` = 0xA1, 0xA2, 0xA3, each with a 1-cycle `rvalid_o` pulse; ends with `rempty_o`=1.
2. Fill and overflow.
   - Write 5 words 0x10..0x14 back-to-back.
   - `walmost_full_o` rises when `count_o`=3, `wfull_o` when `count_o`=4.
   - 0x14 is dropped and `overflow_o` latches 1.
   - Reading out yields exactly 0x10..0x13.
3. Underflow.
   - Pulse `rincr_i` on an empty FIFO: `underflow_o`=1, pointers unchanged, `rvalid_o`=0.
   - `underflow_o` stays 1 until `rst`.
4. Simultaneous traffic and wrap.
   - Prefill 2 words, then 20 cycles of concurrent write/read with an incrementing pattern.
   - `count_o` stays at 2, data order is preserved across multiple pointer wraps, and no error flag is set.
5. FWFT=1.
   - Write 0x55 into an empty FIFO: the next cycle shows `rempty_o`=0 and `rdata_o`=0x55 with no `rincr_i`.
   - Assert `rincr_i` for one cycle: `rempty_o` returns to 1.
6. Reset mid-operation.
   - With `count_o`=3, assert `rst` together with `wincr_i` and `rincr_i`.
   - The next cycle shows all outputs at their reset values, `count_o`=0, and the sticky flags cleared.
